// File: rtl/clken_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module  : clken_timer
// | Desc    : Reloadable down-counting interval timer advanced on clk_en ticks,
// |           with a sticky underflow IRQ. Optional macro: TIMER_ONESHOT_EN.
// | Rev     : 1.0  initial release
// +----------------------------------------------------------------------------
module clken_timer #(
  parameter int PRESCALE = 1024,
  parameter int CNT_W    = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clk_en,
  input  logic             i_wr_reload,
  input  logic             i_wr_ctrl,
  input  logic [7:0]       i_wdata,
  input  logic             i_ack,
  output logic [CNT_W-1:0] o_count,
  output logic             o_running,
  output logic             o_irq
);

  localparam int              PW          = $clog2(PRESCALE);
  localparam logic [PW-1:0]   c_presc_max = PW'(PRESCALE - 1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_reload;
  logic [PW-1:0]    r_presc;
  logic             r_running;
  logic             r_irq;

  logic [CNT_W-1:0] w_reload_nxt;
  logic             w_tick;
  logic             w_presc_zero;
  logic             w_underflow;
  logic             w_oneshot_stop;

  // A reload written on the underflow edge must be the value the counter picks up.
  assign w_reload_nxt = i_wr_reload ? i_wdata[CNT_W-1:0] : r_reload;
  assign w_tick       = i_clk_en & r_running & ~i_wr_ctrl;
  assign w_presc_zero = (r_presc == '0);
  assign w_underflow  = w_tick & w_presc_zero & (r_count == '0);

`ifdef TIMER_ONESHOT_EN
  logic r_oneshot;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_oneshot <= 1'b0;
    end else if (i_wr_ctrl) begin
      r_oneshot <= i_wdata[1];
    end
  end

  assign w_oneshot_stop = r_oneshot;
`else
  assign w_oneshot_stop = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_reload  <= '0;
      r_presc   <= c_presc_max;
      r_running <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_reload <= w_reload_nxt;

      if (i_wr_ctrl) begin
        // Start only takes effect on a stopped timer; a repeated start is ignored.
        if (i_wdata[0] && !r_running) begin
          r_running <= 1'b1;
          r_count   <= w_reload_nxt;
          r_presc   <= c_presc_max;
        end else if (!i_wdata[0]) begin
          r_running <= 1'b0;
        end
      end else if (w_tick) begin
        if (!w_presc_zero) begin
          r_presc <= r_presc - 1'b1;
        end else begin
          r_presc <= c_presc_max;
          if (r_count != '0) begin
            r_count <= r_count - 1'b1;
          end else begin
            r_count <= w_reload_nxt;
            if (w_oneshot_stop) begin
              r_running <= 1'b0;
            end
          end
        end
      end

      // Set has priority over acknowledge.
      if (w_underflow) begin
        r_irq <= 1'b1;
      end else if (i_ack) begin
        r_irq <= 1'b0;
      end
    end
  end

  assign o_count   = r_count;
  assign o_running = r_running;
  assign o_irq     = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_clken_timer.sv
`default_nettype none
// Testbench for clken_timer: PRESCALE=4, CNT_W=7, clk_en every third clk.
// Cycle model feeds a scoreboard queue; directed checks cover the timing cases.
module tb_clken_timer;

  localparam int PRESCALE = 4;
  localparam int CNT_W    = 7;

  logic             clk = 1'b0;
  logic             reset;
  logic             clk_en;
  logic             wr_reload;
  logic             wr_ctrl;
  logic [7:0]       wdata;
  logic             ack;
  logic [CNT_W-1:0] count;
  logic             running;
  logic             irq;

  clken_timer #(.PRESCALE(PRESCALE), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_clk_en   (clk_en),
    .i_wr_reload(wr_reload),
    .i_wr_ctrl  (wr_ctrl),
    .i_wdata    (wdata),
    .i_ack      (ack),
    .o_count    (count),
    .o_running  (running),
    .o_irq      (irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CNT_W-1:0] c;
    logic             r;
    logic             i;
  } exp_t;

  exp_t sbq[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int npulse = 0;

  // reference model state
  logic [CNT_W-1:0] m_count, m_rel;
  int               m_presc;
  logic             m_run, m_irq, m_one;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic next_en();
    return (cyc % 3) == 2;
  endfunction

  task automatic model(input logic rl, input logic ctl, input logic ak,
                       input logic [7:0] wd, input logic rs, input logic en);
    logic [CNT_W-1:0] nrel;
    logic             und;
    if (rs) begin
      m_count = '0; m_rel = '0; m_presc = PRESCALE - 1;
      m_run = 1'b0; m_irq = 1'b0; m_one = 1'b0;
    end else begin
      nrel = rl ? wd[CNT_W-1:0] : m_rel;
      und  = 1'b0;
      if (ctl) begin
`ifdef TIMER_ONESHOT_EN
        m_one = wd[1];
`endif
        if (wd[0] && !m_run) begin
          m_run = 1'b1; m_count = nrel; m_presc = PRESCALE - 1;
        end else if (!wd[0]) begin
          m_run = 1'b0;
        end
      end else if (en && m_run) begin
        if (m_presc != 0) m_presc = m_presc - 1;
        else begin
          m_presc = PRESCALE - 1;
          if (m_count != 0) m_count = m_count - 1;
          else begin
            m_count = nrel;
            und     = 1'b1;
            if (m_one) m_run = 1'b0;
          end
        end
      end
      m_rel = nrel;
      if (und) m_irq = 1'b1;
      else if (ak) m_irq = 1'b0;
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare 1 ns later.
  task automatic step(input logic rl, input logic ctl, input logic ak,
                      input logic [7:0] wd, input logic rs);
    exp_t e;
    reset = rs; wr_reload = rl; wr_ctrl = ctl; ack = ak; wdata = wd;
    clk_en = next_en();
    if (clk_en) npulse++;
    cyc++;
    @(posedge clk);
    model(rl, ctl, ak, wd, rs, clk_en);
    sbq.push_back('{c: m_count, r: m_run, i: m_irq});
    #1;
    e = sbq.pop_front();
    check("sb_count",   32'(count),   32'(e.c));
    check("sb_running", 32'(running), 32'(e.r));
    check("sb_irq",     32'(irq),     32'(e.i));
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_irq();
    for (int k = 0; k < 300 && !irq; k++) idle();
  endtask

  task automatic wait_underflow_next();
    for (int k = 0; k < 300; k++) begin
      if (next_en() && m_run && m_presc == 0 && m_count == 0) break;
      idle();
    end
  endtask

  initial begin
    int frozen;
    // 1: reset then idle
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check("rst_count", 32'(count), 0);
    check("rst_running", 32'(running), 0);
    check("rst_irq", 32'(irq), 0);
    for (int k = 0; k < 50; k++) idle();
    check("idle_count", 32'(count), 0);
    check("idle_irq", 32'(irq), 0);

    // 2: periodic underflow with reload=2
    step(1'b1, 1'b0, 1'b0, 8'd2, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h01, 1'b0);
    check("start_count", 32'(count), 2);
    check("start_running", 32'(running), 1);
    npulse = 0;
    wait_irq();
    check("irq1_pulses", npulse, 12);
    check("irq1_count", 32'(count), 2);
    npulse = 0;
    step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    check("ack_clear", 32'(irq), 0);
    wait_irq();
    check("irq2_pulses", npulse, 12);

    // 3: stop freezes, restart reloads
    step(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'd5, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h01, 1'b0);
    npulse = 0;
    for (int k = 0; k < 100 && npulse < 5; k++) idle();
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    check("stop_count", 32'(count), 4);
    check("stop_running", 32'(running), 0);
    frozen = 32'(count);
    for (int k = 0; k < 30; k++) idle();
    check("frozen_count", 32'(count), frozen);
    step(1'b0, 1'b1, 1'b0, 8'h01, 1'b0);
    check("restart_count", 32'(count), 5);
    npulse = 0;
    for (int k = 0; k < 100 && count == 5; k++) idle();
    check("restart_presc", npulse, 4);

    // 4: ack and reload write on the underflow edge
    wait_underflow_next();
    step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    check("ack_vs_set", 32'(irq), 1);
    wait_underflow_next();
    step(1'b1, 1'b0, 1'b0, 8'd9, 1'b0);
    check("uf_new_reload", 32'(count), 9);

    // 5: reset mid-count
    for (int k = 0; k < 300 && m_count != 1; k++) idle();
    check("pre_rst_count", 32'(count), 1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_running", 32'(running), 0);
    check("mid_rst_irq", 32'(irq), 0);

    // 6: oneshot control (periodic when the option is absent)
    step(1'b1, 1'b0, 1'b0, 8'd1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h03, 1'b0);
    npulse = 0;
    wait_irq();
    check("os_pulses", npulse, 8);
    check("os_count", 32'(count), 1);
`ifdef TIMER_ONESHOT_EN
    check("os_running", 32'(running), 0);
    step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    for (int k = 0; k < 120; k++) idle();
    check("os_no_irq", 32'(irq), 0);
    check("os_still_stopped", 32'(running), 0);
`else
    check("per_running", 32'(running), 1);
    npulse = 0;
    step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    wait_irq();
    check("per_pulses", npulse, 8);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
